// File: rtl/rv32_data_memory_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port data BRAM.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface rv32_data_memory_arbiter_if;
    logic        core_req_i;
    logic [3:0]  core_we_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wdata_i;
    logic        core_gnt_o;
    logic        core_stall_o;
    logic        core_rvalid_o;
    logic [31:0] core_rdata_o;

    logic        dma_req_i;
    logic        dma_lock_i;
    logic [3:0]  dma_we_i;
    logic [31:0] dma_addr_i;
    logic [31:0] dma_wdata_i;
    logic        dma_gnt_o;
    logic        dma_rvalid_o;
    logic [31:0] dma_rdata_o;

    logic        mem_en_o;
    logic [3:0]  mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    modport slave (
        input  core_req_i, core_we_i, core_addr_i, core_wdata_i,
        output core_gnt_o, core_stall_o, core_rvalid_o, core_rdata_o,
        input  dma_req_i, dma_lock_i, dma_we_i, dma_addr_i, dma_wdata_i,
        output dma_gnt_o, dma_rvalid_o, dma_rdata_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output core_req_i, core_we_i, core_addr_i, core_wdata_i,
        input  core_gnt_o, core_stall_o, core_rvalid_o, core_rdata_o,
        output dma_req_i, dma_lock_i, dma_we_i, dma_addr_i, dma_wdata_i,
        input  dma_gnt_o, dma_rvalid_o, dma_rdata_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/rv32_data_memory_arbiter.sv
// Core-priority arbiter for the data BRAM port, with DMA starvation forcing.
// Locked DMA bursts (DMA_BURST state, beat counter) exist only when RV32_ARB_DMA_BURST_EN is defined.
module rv32_data_memory_arbiter #(
    parameter int MAX_WAIT  = 4,
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    rv32_data_memory_arbiter_if.slave bus
);

    typedef enum logic [0:0] {
        ARB       = 1'b0,
        DMA_BURST = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   wait_cnt, wait_next;
    logic               core_gnt, dma_gnt;
    logic               core_rvalid, dma_rvalid;

`ifdef RV32_ARB_DMA_BURST_EN
    logic [CNT_W-1:0]   beat_cnt, beat_next;
`else
    logic               unused_cfg;
    assign unused_cfg = bus.dma_lock_i ^ (MAX_BURST > 0);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ARB;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

`ifdef RV32_ARB_DMA_BURST_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) beat_cnt <= '0;
        else       beat_cnt <= beat_next;
    end
`endif

    always_comb begin
        core_gnt   = 1'b0;
        dma_gnt    = 1'b0;
        state_next = state;
        wait_next  = wait_cnt;
`ifdef RV32_ARB_DMA_BURST_EN
        beat_next  = beat_cnt;
`endif
        if (!rst_i) begin
            case (state)
                ARB: begin
                    if (wait_cnt == CNT_W'(MAX_WAIT) && bus.dma_req_i) dma_gnt  = 1'b1;
                    else if (bus.core_req_i)                           core_gnt = 1'b1;
                    else if (bus.dma_req_i)                            dma_gnt  = 1'b1;

                    if (!bus.dma_req_i || dma_gnt)       wait_next = '0;
                    else if (wait_cnt < CNT_W'(MAX_WAIT)) wait_next = wait_cnt + CNT_W'(1);
`ifdef RV32_ARB_DMA_BURST_EN
                    if (dma_gnt && bus.dma_lock_i) begin
                        state_next = DMA_BURST;
                        beat_next  = CNT_W'(1);
                    end
`endif
                end
`ifdef RV32_ARB_DMA_BURST_EN
                DMA_BURST: begin
                    dma_gnt   = bus.dma_req_i;
                    wait_next = '0;
                    if (dma_gnt) beat_next = beat_cnt + CNT_W'(1);
                    // beat_cnt counts beats already taken, so the grant that brings it to MAX_BURST is the last one
                    if (!bus.dma_lock_i || !bus.dma_req_i ||
                        (dma_gnt && beat_cnt == CNT_W'(MAX_BURST - 1))) begin
                        state_next = ARB;
                        beat_next  = '0;
                    end
                end
`endif
                default: state_next = ARB;
            endcase
        end
    end

    always_comb begin
        bus.mem_we_o    = '0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        if (core_gnt) begin
            bus.mem_we_o    = bus.core_we_i;
            bus.mem_addr_o  = bus.core_addr_i;
            bus.mem_wdata_o = bus.core_wdata_i;
        end else if (dma_gnt) begin
            bus.mem_we_o    = bus.dma_we_i;
            bus.mem_addr_o  = bus.dma_addr_i;
            bus.mem_wdata_o = bus.dma_wdata_i;
        end
    end

    // Read ownership is tracked one cycle deep; reset drops any read in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            core_rvalid <= 1'b0;
            dma_rvalid  <= 1'b0;
        end else begin
            core_rvalid <= core_gnt && (bus.core_we_i == 4'b0000);
            dma_rvalid  <= dma_gnt && (bus.dma_we_i == 4'b0000);
        end
    end

    assign bus.mem_en_o      = core_gnt | dma_gnt;
    assign bus.core_gnt_o    = core_gnt;
    assign bus.dma_gnt_o     = dma_gnt;
    assign bus.core_stall_o  = bus.core_req_i & ~core_gnt;
    assign bus.core_rvalid_o = core_rvalid;
    assign bus.dma_rvalid_o  = dma_rvalid;
    assign bus.core_rdata_o  = bus.mem_rdata_i;
    assign bus.dma_rdata_o   = bus.mem_rdata_i;

endmodule

// File: tb/tb_rv32_data_memory_arbiter.sv
// Bench for rv32_data_memory_arbiter: per-scenario tasks check grants inline, a scoreboard
// checks read returns (owner, data, 1-cycle latency) against a reference memory image.
module tb_rv32_data_memory_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    typedef struct {
        bit          dma;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    logic [31:0] bram [0:1023];
    logic [31:0] refm [0:1023];

    rv32_data_memory_arbiter_if bus();

    rv32_data_memory_arbiter #(.MAX_WAIT(4), .MAX_BURST(8), .CNT_W(4)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] merge(logic [31:0] old, logic [3:0] we, logic [31:0] d);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // BRAM model driven by the DUT's memory port
    always @(posedge clk) begin
        if (!rst && bus.mem_en_o) begin
            if (bus.mem_we_o == 4'b0000) bus.mem_rdata_i <= bram[bus.mem_addr_o[11:2]];
            else bram[bus.mem_addr_o[11:2]] <= merge(bram[bus.mem_addr_o[11:2]], bus.mem_we_o, bus.mem_wdata_o);
        end
    end

    // Read-return scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (bus.core_rvalid_o !== !e.dma || bus.dma_rvalid_o !== e.dma) begin
                    errors++;
                    $display("FAIL rvalid_owner c%0d: got core=%b dma=%b want dma_owner=%0b", cyc, bus.core_rvalid_o, bus.dma_rvalid_o, e.dma);
                end else begin
                    checks++;
                    if ((e.dma ? bus.dma_rdata_o : bus.core_rdata_o) !== e.data) begin
                        errors++;
                        $display("FAIL rdata c%0d: got %h want %h", cyc, e.dma ? bus.dma_rdata_o : bus.core_rdata_o, e.data);
                    end
                end
            end else begin
                checks++;
                if (bus.core_rvalid_o !== 1'b0 || bus.dma_rvalid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL spurious_rvalid c%0d: got core=%b dma=%b want 0/0", cyc, bus.core_rvalid_o, bus.dma_rvalid_o);
                end
            end
        end
    end

    task automatic idle();
        bus.core_req_i = 0; bus.core_we_i = 0; bus.core_addr_i = 0; bus.core_wdata_i = 0;
        bus.dma_req_i = 0; bus.dma_lock_i = 0; bus.dma_we_i = 0; bus.dma_addr_i = 0; bus.dma_wdata_i = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push_rd(bit dma, logic [31:0] addr);
        exp_t e;
        e.dma = dma; e.data = refm[addr[11:2]]; e.cyc = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic ref_wr(logic [31:0] addr, logic [3:0] we, logic [31:0] d);
        refm[addr[11:2]] = merge(refm[addr[11:2]], we, d);
    endtask

    task automatic test_reset();
        idle();
        bus.core_req_i = 1; bus.dma_req_i = 1;
        @(negedge clk);
        checks++; if (bus.core_gnt_o !== 0 || bus.dma_gnt_o !== 0) begin errors++; $display("FAIL reset_gnt: got %b%b want 00", bus.core_gnt_o, bus.dma_gnt_o); end
        checks++; if (bus.mem_en_o !== 0 || bus.mem_we_o !== 0) begin errors++; $display("FAIL reset_mem: got en=%b we=%h want 0/0", bus.mem_en_o, bus.mem_we_o); end
        checks++; if (bus.core_rvalid_o !== 0 || bus.dma_rvalid_o !== 0) begin errors++; $display("FAIL reset_rvalid: got %b%b want 00", bus.core_rvalid_o, bus.dma_rvalid_o); end
        idle();
        step();
        rst = 0;
        @(negedge clk);
        checks++; if (bus.mem_en_o !== 0 || bus.mem_addr_o !== 0 || bus.mem_wdata_o !== 0) begin errors++; $display("FAIL idle_mux: got en=%b addr=%h wdata=%h want 0", bus.mem_en_o, bus.mem_addr_o, bus.mem_wdata_o); end
        step();
    endtask

    task automatic test_core_read();
        bus.core_req_i = 1; bus.core_addr_i = 32'h100;
        @(negedge clk);
        checks++; if (bus.core_gnt_o !== 1 || bus.dma_gnt_o !== 0 || bus.core_stall_o !== 0) begin errors++; $display("FAIL core_read_gnt: got c=%b d=%b s=%b want 1 0 0", bus.core_gnt_o, bus.dma_gnt_o, bus.core_stall_o); end
        checks++; if (bus.mem_en_o !== 1 || bus.mem_we_o !== 0 || bus.mem_addr_o !== 32'h100) begin errors++; $display("FAIL core_read_mem: got en=%b we=%h addr=%h want 1 0 100", bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o); end
        push_rd(0, 32'h100);
        step(); idle();
        step();
    endtask

    task automatic test_starvation();
        bit exp_d;
        for (int i = 0; i < 6; i++) begin
            bus.core_req_i = 1; bus.core_we_i = 0; bus.core_addr_i = 32'h300 + 32'(4 * i);
            bus.dma_req_i = 1; bus.dma_we_i = 4'hF; bus.dma_addr_i = 32'h200; bus.dma_wdata_i = 32'h1234_5678;
            exp_d = (i == 4);
            @(negedge clk);
            checks++; if (bus.core_gnt_o !== !exp_d || bus.dma_gnt_o !== exp_d || bus.core_stall_o !== exp_d) begin
                errors++; $display("FAIL starve_gnt c%0d: got c=%b d=%b s=%b want dma=%0b", i, bus.core_gnt_o, bus.dma_gnt_o, bus.core_stall_o, exp_d); end
            if (exp_d) begin
                checks++; if (bus.mem_addr_o !== 32'h200 || bus.mem_we_o !== 4'hF || bus.mem_wdata_o !== 32'h1234_5678) begin
                    errors++; $display("FAIL starve_mem: got addr=%h we=%h wd=%h want 200 f 12345678", bus.mem_addr_o, bus.mem_we_o, bus.mem_wdata_o); end
                ref_wr(32'h200, 4'hF, 32'h1234_5678);
            end else push_rd(0, bus.core_addr_i);
            step();
        end
        idle();
        bus.dma_req_i = 1; bus.dma_addr_i = 32'h200;
        @(negedge clk);
        checks++; if (bus.dma_gnt_o !== 1) begin errors++; $display("FAIL dma_readback_gnt: got %b want 1", bus.dma_gnt_o); end
        push_rd(1, 32'h200);
        step(); idle();
        step();
    endtask

    task automatic test_mixed();
        bus.dma_req_i = 1; bus.dma_addr_i = 32'h40;
        @(negedge clk);
        checks++; if (bus.dma_gnt_o !== 1 || bus.core_gnt_o !== 0) begin errors++; $display("FAIL mixed_dma_gnt: got c=%b d=%b want 0 1", bus.core_gnt_o, bus.dma_gnt_o); end
        push_rd(1, 32'h40);
        step(); idle();
        bus.core_req_i = 1; bus.core_we_i = 4'b0011; bus.core_addr_i = 32'h44; bus.core_wdata_i = 32'hCAFE_BABE;
        @(negedge clk);
        checks++; if (bus.core_gnt_o !== 1 || bus.mem_we_o !== 4'b0011 || bus.mem_addr_o !== 32'h44) begin
            errors++; $display("FAIL mixed_core_wr: got gnt=%b we=%h addr=%h want 1 3 44", bus.core_gnt_o, bus.mem_we_o, bus.mem_addr_o); end
        ref_wr(32'h44, 4'b0011, 32'hCAFE_BABE);
        step(); idle();
        bus.core_req_i = 1; bus.core_addr_i = 32'h44;
        push_rd(0, 32'h44);
        step(); idle();
        step();
    endtask

    task automatic test_burst();
        bit exp_d;
        int n = 0;
        for (int i = 0; i < 14; i++) begin
            bus.core_req_i = 1; bus.core_addr_i = 32'h500 + 32'(4 * i);
            bus.dma_req_i = 1; bus.dma_lock_i = 1; bus.dma_addr_i = 32'h400 + 32'(4 * n);
`ifdef RV32_ARB_DMA_BURST_EN
            exp_d = (i >= 4 && i <= 11);
`else
            exp_d = (i % 5 == 4);
`endif
            @(negedge clk);
            checks++; if (bus.core_gnt_o !== !exp_d || bus.dma_gnt_o !== exp_d) begin
                errors++; $display("FAIL burst_gnt c%0d: got c=%b d=%b want dma=%0b", i, bus.core_gnt_o, bus.dma_gnt_o, exp_d); end
            if (exp_d) begin push_rd(1, bus.dma_addr_i); n++; end
            else push_rd(0, bus.core_addr_i);
            step();
        end
        idle();
        step();
    endtask

    task automatic test_lock_drop();
        bit [4:0] pat;
        bit exp_d;
        int n = 0;
`ifdef RV32_ARB_DMA_BURST_EN
        pat = 5'b01111;
`else
        pat = 5'b00001;
`endif
        for (int i = 0; i < 5; i++) begin
            bus.core_req_i = (i != 0); bus.core_addr_i = 32'h700 + 32'(4 * i);
            bus.dma_req_i = 1; bus.dma_lock_i = (i < 3); bus.dma_addr_i = 32'h600 + 32'(4 * n);
            exp_d = pat[i];
            @(negedge clk);
            checks++; if (bus.dma_gnt_o !== exp_d || bus.core_gnt_o !== (bus.core_req_i && !exp_d)) begin
                errors++; $display("FAIL lock_drop_gnt c%0d: got c=%b d=%b want dma=%0b", i, bus.core_gnt_o, bus.dma_gnt_o, exp_d); end
            if (exp_d) begin push_rd(1, bus.dma_addr_i); n++; end
            else if (bus.core_req_i) push_rd(0, bus.core_addr_i);
            step();
        end
        idle();
        step();
    endtask

    task automatic test_reset_inflight();
        bus.core_req_i = 1; bus.core_addr_i = 32'h104;
        @(negedge clk);
        checks++; if (bus.core_gnt_o !== 1) begin errors++; $display("FAIL inflight_gnt: got %b want 1", bus.core_gnt_o); end
        #1 rst = 1;
        step();
        checks++; if (bus.core_rvalid_o !== 0 || bus.dma_rvalid_o !== 0) begin errors++; $display("FAIL inflight_rvalid: got %b%b want 00", bus.core_rvalid_o, bus.dma_rvalid_o); end
        checks++; if (bus.core_gnt_o !== 0 || bus.mem_en_o !== 0) begin errors++; $display("FAIL inflight_rst_gnt: got gnt=%b en=%b want 0 0", bus.core_gnt_o, bus.mem_en_o); end
        idle();
        step();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.core_gnt_o !== 0 || bus.dma_gnt_o !== 0 || bus.mem_en_o !== 0) begin
                errors++; $display("FAIL post_reset_idle c%0d: got c=%b d=%b en=%b want 0", i, bus.core_gnt_o, bus.dma_gnt_o, bus.mem_en_o); end
            step();
        end
        bus.core_req_i = 1; bus.core_we_i = 4'hF; bus.core_addr_i = 32'h108; bus.core_wdata_i = 32'h0BAD_F00D;
        @(negedge clk);
        checks++; if (bus.core_gnt_o !== 1) begin errors++; $display("FAIL post_reset_gnt: got %b want 1", bus.core_gnt_o); end
        ref_wr(32'h108, 4'hF, 32'h0BAD_F00D);
        step(); idle();
        bus.core_req_i = 1; bus.core_addr_i = 32'h108;
        push_rd(0, 32'h108);
        step(); idle();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 1024; k++) begin
            bram[k] = {k[15:0] ^ 16'h5A5A, k[15:0]};
            refm[k] = {k[15:0] ^ 16'h5A5A, k[15:0]};
        end
        bram[32'h100 >> 2] = 32'hDEAD_BEEF;
        refm[32'h100 >> 2] = 32'hDEAD_BEEF;
        bus.mem_rdata_i = 32'h0;
        test_reset();
        test_core_read();
        test_starvation();
        test_mixed();
        test_burst();
        test_lock_drop();
        test_reset_inflight();
        step(); step();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d pending reads want 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
